// File: rtl/i2s_rx_fifo.sv
// I2S receiver: deserialises one slot per lr_clk phase (one-bit-delayed I2S framing)
// and queues completed words with their channel tag in a small synchronous FIFO.
module i2s_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lr_clk,
  input  logic                     i2s_in,
  input  logic                     out_ready,
  input  logic                     clr_flags,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_chan,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     short_frame,
  output logic                     sign_err
);

  localparam int PW       = $clog2(DEPTH);
  localparam int CNTW     = PW + 1;
  localparam int CW       = $clog2(WORD_W + 1);
  localparam int SIGN_LSB = 22;

  // Output handshake: a word leaves the FIFO on a rising clk edge where
  // out_valid && out_ready; out_data/out_chan hold the oldest word while out_valid.

  logic              ws_d;
  logic              frame_open;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-2:0] shreg;
  logic              chan;
  logic              pend_valid;
  logic [WORD_W-1:0] pend_data;
  logic              pend_chan;

  logic ws_edge, last_bit, short_hit;

  assign ws_edge   = (lr_clk != ws_d);
  assign last_bit  = frame_open && (bit_cnt == CW'(WORD_W - 1));
  assign short_hit = ws_edge && frame_open && (bit_cnt < CW'(WORD_W - 1));

  // Deserialiser. The LSB may arrive in the same cycle as the next ws edge,
  // so completion is checked before the new frame is opened.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_d       <= 1'b0;
      frame_open <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      chan       <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_chan  <= 1'b0;
    end else begin
      ws_d       <= lr_clk;
      pend_valid <= last_bit;
      if (last_bit) begin
        pend_data <= {shreg, i2s_in};
        pend_chan <= chan;
      end
      if (ws_edge) begin
        frame_open <= 1'b1;
        bit_cnt    <= '0;
        chan       <= lr_clk;
      end else if (frame_open && (bit_cnt < CW'(WORD_W))) begin
        shreg   <= {shreg[WORD_W-3:0], i2s_in};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  logic [WORD_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]   count;
  logic              full, pop, wr_en, drop, sign_bad;

  assign full     = (count == CNTW'(DEPTH));
  assign pop      = out_valid && out_ready;
  assign wr_en    = pend_valid && (!full || pop);
  assign drop     = pend_valid && full && !pop;
  assign sign_bad = !((&pend_data[WORD_W-1:SIGN_LSB]) || ~(|pend_data[WORD_W-1:SIGN_LSB]));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {pend_chan, pend_data};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(wr_en) - CNTW'(pop);
    end
  end

  // Sticky flags: a set condition in the same cycle beats clr_flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      sign_err    <= 1'b0;
    end else begin
      overflow    <= drop                 || (overflow    && !clr_flags);
      short_frame <= short_hit            || (short_frame && !clr_flags);
      sign_err    <= (wr_en && sign_bad)  || (sign_err    && !clr_flags);
    end
  end

  assign out_valid  = (count != '0);
  assign fill_level = count;
  assign out_data   = out_valid ? mem[rd_ptr][WORD_W-1:0] : '0;
  assign out_chan   = out_valid ? mem[rd_ptr][WORD_W]     : 1'b0;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Directed bench for i2s_rx_fifo: drives an I2S stream frame by frame and checks
// popped words against an expected queue plus flag/level checks at chosen points.
module tb_i2s_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        lr_clk;
  logic        i2s_in;
  logic        out_ready;
  logic        clr_flags;
  logic [31:0] out_data;
  logic        out_chan;
  logic        out_valid;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        short_frame;
  logic        sign_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  logic        nxt_lsb;

  i2s_rx_fifo #(.DEPTH(8), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .lr_clk(lr_clk), .i2s_in(i2s_in),
    .out_ready(out_ready), .clr_flags(clr_flags),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .fill_level(fill_level), .overflow(overflow),
    .short_frame(short_frame), .sign_err(sign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_pop: observed %0h expected none", {out_chan, out_data});
      end else begin
        check("pop_word", {out_chan, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic ws, input logic d);
    @(posedge clk);
    #1;
    lr_clk = ws;
    i2s_in = d;
  endtask

  task automatic open_frame(input logic ch);
    drive(ch, nxt_lsb);
  endtask

  task automatic body(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive(lr_clk, w[i]);
  endtask

  task automatic frame(input logic ch, input logic [31:0] w, input logic push);
    open_frame(ch);
    body(w, 31, 1);
    nxt_lsb = w[0];
    if (push) exp_q.push_back({ch, w});
  endtask

  initial begin
    rst = 1'b0; lr_clk = 1'b0; i2s_in = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    nxt_lsb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_fill", fill_level, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_chan, 0);
    check("rst_flags", {overflow, short_frame, sign_err}, 0);
    rst = 1'b1;

    // Noise before the first ws edge must be ignored.
    for (int i = 0; i < 6; i++) drive(1'b0, 1'($urandom_range(0, 1)));
    check("pre_edge_fill", fill_level, 0);
    check("pre_edge_flags", {overflow, short_frame, sign_err}, 0);

    // Basic stereo stream with continuous popping.
    frame(1'b1, 32'hFFFF_FFF0, 1'b1);
    frame(1'b0, 32'h0012_3456, 1'b1);
    frame(1'b1, 32'hFFFA_BCDE, 1'b1);
    open_frame(1'b0);
    drive(1'b0, 1'b0);
    check("lat_valid_c1", out_valid, 0);
    drive(1'b0, 1'b0);
    check("lat_valid_c2", out_valid, 1);
    check("lat_data", {out_chan, out_data}, {1'b1, 32'hFFFA_BCDE});
    drive(1'b0, 1'b0);
    out_ready = 1'b0;
    check("t1_empty", out_valid, 0);
    check("t1_flags", {overflow, short_frame, sign_err}, 0);

    // Fill the FIFO with words 1..9 while nothing is popped.
    body(32'd1, 28, 1);
    nxt_lsb = 1'b1;
    exp_q.push_back({1'b0, 32'd1});
    for (int k = 2; k <= 9; k++) frame(k[0] ? 1'b0 : 1'b1, k, k <= 8);
    open_frame(1'b1);
    body(32'hA, 31, 29);
    check("full_level", fill_level, 8);
    check("full_overflow", overflow, 1);
    check("full_head", out_data, 32'd1);
    clr_flags = 1'b1;
    body(32'hA, 28, 28);
    clr_flags = 1'b0;
    body(32'hA, 27, 27);
    check("ovf_cleared", overflow, 0);
    body(32'hA, 26, 1);
    nxt_lsb = 1'b0;
    exp_q.push_back({1'b1, 32'hA});

    // Word 10 is written in the same cycle as the first pop.
    open_frame(1'b0);
    drive(1'b0, 1'b0);
    out_ready = 1'b1;
    drive(1'b0, 1'b0);
    check("simul_level", fill_level, 8);
    check("simul_overflow", overflow, 0);
    check("simul_head", out_data, 32'd2);

    // Short frame after 10 bits of 0x12345678.
    body(32'h1234_5678, 29, 22);
    nxt_lsb = 1'b1;
    frame(1'b1, 32'hFFC0_1234, 1'b1);
    check("short_set", short_frame, 1);
    check("short_nopush", fill_level, 0);
    clr_flags = 1'b1;
    open_frame(1'b0);
    clr_flags = 1'b0;
    body(32'h00C0_0000, 31, 31);
    check("short_cleared", short_frame, 0);
    body(32'h00C0_0000, 30, 1);
    nxt_lsb = 1'b0;
    exp_q.push_back({1'b0, 32'h00C0_0000});

    // Sign error on 0x00C00000, then clear.
    open_frame(1'b1);
    body(32'h8000_0000, 31, 29);
    check("sign_set", sign_err, 1);
    clr_flags = 1'b1;
    body(32'h8000_0000, 28, 28);
    clr_flags = 1'b0;
    body(32'h8000_0000, 27, 27);
    check("sign_cleared", sign_err, 0);
    body(32'h8000_0000, 26, 1);
    nxt_lsb = 1'b0;
    exp_q.push_back({1'b1, 32'h8000_0000});

    // clr_flags in the same cycle as a bad-sign write: set wins.
    open_frame(1'b0);
    drive(1'b0, 1'b0);
    clr_flags = 1'b1;
    drive(1'b0, 1'b0);
    clr_flags = 1'b0;
    check("set_beats_clr", sign_err, 1);
    clr_flags = 1'b1;
    body(32'h15, 29, 29);
    clr_flags = 1'b0;
    body(32'h15, 28, 28);
    check("sign_cleared2", sign_err, 0);
    body(32'h15, 27, 1);
    nxt_lsb = 1'b1;
    exp_q.push_back({1'b0, 32'h15});

    // Queue three words, then reset in the middle of a left frame.
    open_frame(1'b1);
    body(32'h16, 31, 28);
    out_ready = 1'b0;
    body(32'h16, 27, 1);
    nxt_lsb = 1'b0;
    frame(1'b0, 32'h17, 1'b0);
    frame(1'b1, 32'h18, 1'b0);
    open_frame(1'b0);
    body(32'hFFFF_FFFF, 31, 22);
    check("pre_rst_level", fill_level, 3);
    check("pre_rst_head", {out_chan, out_data}, {1'b1, 32'h16});
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_fill", fill_level, 0);
    check("mid_rst_data", {out_chan, out_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    body(32'hFFFF_FFFF, 21, 1);
    nxt_lsb = 1'b1;
    frame(1'b1, 32'h20, 1'b1);
    check("post_rst_short", short_frame, 0);
    check("post_rst_fill", fill_level, 0);
    open_frame(1'b0);
    body(32'h0, 31, 27);
    check("queue_drained", 33'(exp_q.size()), 0);
    check("final_flags", {overflow, short_frame, sign_err}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
